// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the RAM data-port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } arb_master_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int unsigned DEFAULT_MAX_HOLD = 16;

  // Ownership state corresponding to a master.
  function automatic arb_state_e own_state(input arb_master_e m);
    return (m == M0) ? OWN_M0 : OWN_M1;
  endfunction

  // The master that is not m.
  function automatic arb_master_e other_master(input arb_master_e m);
    return (m == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/data_bus_arbiter_hold_counter.sv
// Saturating consecutive-grant counter used to bound starvation.
// Clear and increment in the same cycle yields 1 (restart counting).
module arb_hold_counter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] count_q;
  logic [HOLD_W-1:0] count_d;

  // Next count: optional clear, then saturating increment.
  always_comb begin
    count_d = i_clr ? '0 : count_q;
    if (i_inc && (count_d < LIMIT)) begin
      count_d = count_d + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_at_limit = (count_q == LIMIT);

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the single synchronous RAM data port.
// M0 = core data port, M1 = UART loader / debug master.
// Optional macro ARB_RR_EN: round-robin on simultaneous requests from IDLE;
// undefined gives fixed M0 priority.
module data_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_m0_req,
  input  logic            i_m0_lock,
  input  logic            i_m0_we,
  input  logic [XLEN-1:0] i_m0_addr,
  input  logic [XLEN-1:0] i_m0_wdata,
  input  logic [1:0]      i_m0_size,
  output logic            o_m0_gnt,
  output logic            o_m0_rvalid,
  output logic [XLEN-1:0] o_m0_rdata,
  input  logic            i_m1_req,
  input  logic            i_m1_lock,
  input  logic            i_m1_we,
  input  logic [XLEN-1:0] i_m1_addr,
  input  logic [XLEN-1:0] i_m1_wdata,
  input  logic [1:0]      i_m1_size,
  output logic            o_m1_gnt,
  output logic            o_m1_rvalid,
  output logic [XLEN-1:0] o_m1_rdata,
  output logic [XLEN-1:0] o_s_addr,
  output logic [XLEN-1:0] o_s_wdata,
  output logic [1:0]      o_s_size,
  output logic            o_s_we,
  input  logic [XLEN-1:0] i_s_rdata
);

  arb_state_e  state_q, state_d;
  arb_master_e owner_q, owner_d;
  arb_master_e rd_owner_q, rd_owner_d;
  logic        rd_pend_q, rd_pend_d;
  logic [XLEN-1:0] m0_rdata_q, m0_rdata_d;
  logic [XLEN-1:0] m1_rdata_q, m1_rdata_d;

`ifdef ARB_RR_EN
  arb_master_e last_q, last_d;
`endif

  logic        gnt_v;
  arb_master_e gnt_m;
  arb_master_e mux_m;
  arb_master_e hold_owner;
  logic        owner_req, owner_lock, other_req;
  logic        hold_other_req;
  logic        owner_change;
  logic        sel_we;
  logic        hold_clr, hold_inc, hold_at_limit;
  logic        m0_rvalid, m1_rvalid;

  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_hold (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (hold_clr),
    .i_inc      (hold_inc),
    .o_at_limit (hold_at_limit)
  );

  // Arbitration: grant selection, next state/owner, hold control, read tracking.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rd_owner_d = rd_owner_q;
    rd_pend_d  = 1'b0;
    gnt_v      = 1'b0;
    gnt_m      = M0;
    owner_req  = (owner_q == M0) ? i_m0_req  : i_m1_req;
    owner_lock = (owner_q == M0) ? i_m0_lock : i_m1_lock;
    other_req  = (owner_q == M0) ? i_m1_req  : i_m0_req;

    case (state_q)
      IDLE: begin
        if (i_m0_req && i_m1_req) begin
          gnt_v = 1'b1;
`ifdef ARB_RR_EN
          gnt_m = other_master(last_q);
`else
          gnt_m = M0;
`endif
        end else if (i_m0_req) begin
          gnt_v = 1'b1;
          gnt_m = M0;
        end else if (i_m1_req) begin
          gnt_v = 1'b1;
          gnt_m = M1;
        end
      end
      OWN_M0, OWN_M1: begin
        // Hold limit outranks both the owner's request and its lock.
        if (other_req && hold_at_limit) begin
          gnt_v = 1'b1;
          gnt_m = other_master(owner_q);
        end else if (owner_req) begin
          gnt_v = 1'b1;
          gnt_m = owner_q;
        end else if (owner_lock) begin
          gnt_v = 1'b0;
        end else if (other_req) begin
          gnt_v = 1'b1;
          gnt_m = other_master(owner_q);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (gnt_v) begin
      state_d = own_state(gnt_m);
      owner_d = gnt_m;
    end

    owner_change = gnt_v && (state_q != own_state(gnt_m));

    // Hold counts grants to the (new) owner while the other side waits.
    hold_owner     = gnt_v ? gnt_m : owner_q;
    hold_other_req = (hold_owner == M0) ? i_m1_req : i_m0_req;
    hold_clr       = owner_change || !hold_other_req || (state_d == IDLE);
    hold_inc       = gnt_v && hold_other_req;

    sel_we = (gnt_m == M0) ? i_m0_we : i_m1_we;
    if (gnt_v && !sel_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = gnt_m;
    end
  end

`ifdef ARB_RR_EN
  // Round-robin history: remember the master taking ownership.
  always_comb begin
    last_d = last_q;
    if (owner_change) begin
      last_d = gnt_m;
    end
  end
`endif

  // Slave-side mux and read-return routing.
  always_comb begin
    mux_m       = gnt_v ? gnt_m : owner_q;
    o_s_addr    = (mux_m == M0) ? i_m0_addr  : i_m1_addr;
    o_s_wdata   = (mux_m == M0) ? i_m0_wdata : i_m1_wdata;
    o_s_size    = (mux_m == M0) ? i_m0_size  : i_m1_size;
    o_s_we      = gnt_v && sel_we;
    o_m0_gnt    = gnt_v && (gnt_m == M0);
    o_m1_gnt    = gnt_v && (gnt_m == M1);
    m0_rvalid   = rd_pend_q && (rd_owner_q == M0);
    m1_rvalid   = rd_pend_q && (rd_owner_q == M1);
    o_m0_rvalid = m0_rvalid;
    o_m1_rvalid = m1_rvalid;
    o_m0_rdata  = m0_rvalid ? i_s_rdata : m0_rdata_q;
    o_m1_rdata  = m1_rvalid ? i_s_rdata : m1_rdata_q;
    m0_rdata_d  = o_m0_rdata;
    m1_rdata_d  = o_m1_rdata;
  end

  // State, ownership, pending-read and held read-data registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      owner_q    <= M0;
      rd_owner_q <= M0;
      rd_pend_q  <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rd_owner_q <= rd_owner_d;
      rd_pend_q  <= rd_pend_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

`ifdef ARB_RR_EN
  // Round-robin history register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= M1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed self-checking bench for data_bus_arbiter (MAX_HOLD overridden to 4).
module tb_data_bus_arbiter;

  localparam int unsigned XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_m0_req, i_m0_lock, i_m0_we;
  logic [XLEN-1:0] i_m0_addr, i_m0_wdata;
  logic [1:0]      i_m0_size;
  logic            o_m0_gnt, o_m0_rvalid;
  logic [XLEN-1:0] o_m0_rdata;
  logic            i_m1_req, i_m1_lock, i_m1_we;
  logic [XLEN-1:0] i_m1_addr, i_m1_wdata;
  logic [1:0]      i_m1_size;
  logic            o_m1_gnt, o_m1_rvalid;
  logic [XLEN-1:0] o_m1_rdata;
  logic [XLEN-1:0] o_s_addr, o_s_wdata;
  logic [1:0]      o_s_size;
  logic            o_s_we;
  logic [XLEN-1:0] i_s_rdata;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  logic        exp_m0_first;

  data_bus_arbiter #(
    .XLEN     (XLEN),
    .MAX_HOLD (4),
    .HOLD_W   (8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_m0_req    (i_m0_req),
    .i_m0_lock   (i_m0_lock),
    .i_m0_we     (i_m0_we),
    .i_m0_addr   (i_m0_addr),
    .i_m0_wdata  (i_m0_wdata),
    .i_m0_size   (i_m0_size),
    .o_m0_gnt    (o_m0_gnt),
    .o_m0_rvalid (o_m0_rvalid),
    .o_m0_rdata  (o_m0_rdata),
    .i_m1_req    (i_m1_req),
    .i_m1_lock   (i_m1_lock),
    .i_m1_we     (i_m1_we),
    .i_m1_addr   (i_m1_addr),
    .i_m1_wdata  (i_m1_wdata),
    .i_m1_size   (i_m1_size),
    .o_m1_gnt    (o_m1_gnt),
    .o_m1_rvalid (o_m1_rvalid),
    .o_m1_rdata  (o_m1_rdata),
    .o_s_addr    (o_s_addr),
    .o_s_wdata   (o_s_wdata),
    .o_s_size    (o_s_size),
    .o_s_we      (o_s_we),
    .i_s_rdata   (i_s_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic e0, input logic e1, input logic ewe);
    chk({tag, " m0_gnt"}, {31'd0, o_m0_gnt}, {31'd0, e0});
    chk({tag, " m1_gnt"}, {31'd0, o_m1_gnt}, {31'd0, e1});
    chk({tag, " s_we"},   {31'd0, o_s_we},   {31'd0, ewe});
  endtask

  task automatic chk_rv(input string tag, input logic e0, input logic e1);
    chk({tag, " m0_rvalid"}, {31'd0, o_m0_rvalid}, {31'd0, e0});
    chk({tag, " m1_rvalid"}, {31'd0, o_m1_rvalid}, {31'd0, e1});
  endtask

  // Advance to just after the next active edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_m0_req = 0; i_m0_lock = 0; i_m0_we = 0; i_m0_addr = '0; i_m0_wdata = '0; i_m0_size = 2'd0;
    i_m1_req = 0; i_m1_lock = 0; i_m1_we = 0; i_m1_addr = '0; i_m1_wdata = '0; i_m1_size = 2'd0;
    i_s_rdata = '0;
  endtask

  initial begin
    clear_inputs();
    i_rst_n = 1'b0;

    // Reset state
    @(negedge i_clk);
    chk_gnt("rst", 0, 0, 0);
    chk_rv("rst", 0, 0);
    chk("rst m0_rdata", o_m0_rdata, 32'h0);
    chk("rst m1_rdata", o_m1_rdata, 32'h0);
    chk("rst s_addr", o_s_addr, 32'h0);
    chk("rst s_wdata", o_s_wdata, 32'h0);
    chk("rst s_size", {30'd0, o_s_size}, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    next_cycle();

    // Single M0 read
    i_m0_req = 1; i_m0_addr = 32'h4000_0010; i_m0_size = 2'd2;
    @(negedge i_clk);
    chk_gnt("rd0 grant", 1, 0, 0);
    chk("rd0 s_addr", o_s_addr, 32'h4000_0010);
    chk("rd0 s_size", {30'd0, o_s_size}, 32'd2);
    chk_rv("rd0 grant", 0, 0);
    next_cycle();
    i_m0_req = 0; i_s_rdata = 32'hDEAD_BEEF;
    @(negedge i_clk);
    chk_rv("rd0 return", 1, 0);
    chk("rd0 m0_rdata", o_m0_rdata, 32'hDEAD_BEEF);
    chk("rd0 m1_rdata", o_m1_rdata, 32'h0);
    chk_gnt("rd0 return", 0, 0, 0);
    next_cycle();
    i_s_rdata = 32'h1234_5678;
    @(negedge i_clk);
    chk_rv("rd0 pulse", 0, 0);
    chk("rd0 m0_rdata held", o_m0_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Simultaneous request from IDLE (both writes)
`ifdef ARB_RR_EN
    exp_m0_first = 1'b0;   // last owner change went to M0
`else
    exp_m0_first = 1'b1;
`endif
    i_m0_req = 1; i_m0_we = 1; i_m0_addr = 32'h4000_0020;
    i_m1_req = 1; i_m1_we = 1; i_m1_addr = 32'h4000_0030;
    @(negedge i_clk);
    chk_gnt("simul", exp_m0_first, !exp_m0_first, 1);
    chk("simul s_addr", o_s_addr, exp_m0_first ? 32'h4000_0020 : 32'h4000_0030);
    next_cycle();
    clear_inputs();
    @(negedge i_clk);
    chk_gnt("simul quiet", 0, 0, 0);
    next_cycle();
    @(negedge i_clk);
    chk_gnt("idle quiet", 0, 0, 0);
    chk_rv("idle quiet", 0, 0);
    next_cycle();

    // Locked M1 write burst with M0 waiting
    i_m1_req = 1; i_m1_lock = 1; i_m1_we = 1; i_m1_size = 2'd2;
    for (int k = 0; k < 4; k++) begin
      i_m1_addr  = 32'h4000_0000 + 32'(4 * k);
      i_m1_wdata = 32'hA000_0000 + 32'(k);
      if (k > 0) begin
        i_m0_req = 1; i_m0_we = 0; i_m0_addr = 32'h4000_0100;
      end
      @(negedge i_clk);
      chk_gnt($sformatf("burst beat%0d", k), 0, 1, 1);
      chk($sformatf("burst addr%0d", k), o_s_addr, 32'h4000_0000 + 32'(4 * k));
      chk($sformatf("burst wdata%0d", k), o_s_wdata, 32'hA000_0000 + 32'(k));
      next_cycle();
    end
    i_m1_req = 0;   // lock still held: nobody granted
    @(negedge i_clk);
    chk_gnt("burst locked idle", 0, 0, 0);
    next_cycle();
    i_m1_lock = 0; i_m1_we = 0;
    @(negedge i_clk);
    chk_gnt("burst release", 1, 0, 0);
    chk("burst release addr", o_s_addr, 32'h4000_0100);
    next_cycle();
    i_m0_req = 0; i_s_rdata = 32'hCAFE_F00D;
    @(negedge i_clk);
    chk_rv("burst m0 return", 1, 0);
    chk("burst m0_rdata", o_m0_rdata, 32'hCAFE_F00D);
    next_cycle();
    clear_inputs();

    // Starvation limit (MAX_HOLD = 4)
    i_m0_req = 1; i_m0_lock = 1; i_m0_we = 0; i_m0_addr = 32'h4000_00A0;
    @(negedge i_clk);
    chk_gnt("hold s1", 1, 0, 0);
    next_cycle();
    i_m1_req = 1; i_m1_we = 0; i_m1_addr = 32'h4000_0200;
    for (int k = 0; k < 4; k++) begin
      i_s_rdata = 32'h0000_0100 + 32'(k);
      @(negedge i_clk);
      chk_gnt($sformatf("hold m0 grant%0d", k), 1, 0, 0);
      chk_rv($sformatf("hold m0 ret%0d", k), 1, 0);
      chk($sformatf("hold m0_rdata%0d", k), o_m0_rdata, 32'h0000_0100 + 32'(k));
      next_cycle();
    end
    i_s_rdata = 32'h0000_0104;
    @(negedge i_clk);
    chk_gnt("hold handover", 0, 1, 0);
    chk("hold handover addr", o_s_addr, 32'h4000_0200);
    chk_rv("hold last m0 ret", 1, 0);
    chk("hold last m0_rdata", o_m0_rdata, 32'h0000_0104);
    chk("hold m1_rdata before", o_m1_rdata, 32'h0);
    next_cycle();
    clear_inputs();
    i_s_rdata = 32'h0000_0BBB;
    @(negedge i_clk);
    chk_rv("hold m1 ret", 0, 1);
    chk("hold m1_rdata", o_m1_rdata, 32'h0000_0BBB);
    chk("hold m0_rdata kept", o_m0_rdata, 32'h0000_0104);
    next_cycle();
    i_s_rdata = '0;
    @(negedge i_clk);
    chk_gnt("hold quiet", 0, 0, 0);
    next_cycle();

    // Reset mid-read
    i_m0_req = 1; i_m0_addr = 32'h4000_0300;
    @(negedge i_clk);
    chk_gnt("rstmid grant", 1, 0, 0);
    next_cycle();
    clear_inputs();
    i_rst_n = 1'b0;
    i_s_rdata = 32'h5555_5555;
    @(negedge i_clk);
    chk_rv("rstmid", 0, 0);
    chk_gnt("rstmid", 0, 0, 0);
    chk("rstmid m0_rdata", o_m0_rdata, 32'h0);
    chk("rstmid m1_rdata", o_m1_rdata, 32'h0);
    chk("rstmid s_addr", o_s_addr, 32'h0);
    next_cycle();
    i_rst_n = 1'b1;
    i_m1_req = 1; i_m1_we = 1; i_m1_addr = 32'h4000_0400;
    @(negedge i_clk);
    chk_gnt("rstmid m1 grant", 0, 1, 1);
    chk_rv("rstmid after", 0, 0);
    chk("rstmid m1 addr", o_s_addr, 32'h4000_0400);
    next_cycle();
    clear_inputs();
    @(negedge i_clk);
    chk_rv("rstmid write", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single RAM data port between two masters: M0 = core data port, M1 = UART program loader / debug master.
- Sits between the masters and the RAM data port.
- The RAM read is synchronous, so read data returns exactly 1 cycle after the address is presented.
- Provides a per-master req/gnt handshake, routes read data back to the owning master with an rvalid pulse, supports locked bursts, and bounds starvation with a hold counter.

Parameters:
- XLEN, 32, address/data width
- MAX_HOLD, 16, max consecutive grants to one master while the other is requesting (range 1..255)
- HOLD_W, 8, hold counter width; requires MAX_HOLD < 2**HOLD_W

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_m0_req  in  1  M0 access request
- i_m0_lock  in  1  M0 keeps ownership after the current beat
- i_m0_we  in  1  M0 write enable
- i_m0_addr  in  XLEN  M0 byte address
- i_m0_wdata  in  XLEN  M0 write data
- i_m0_size  in  2  M0 size: 0=byte, 1=half, 2=word
- o_m0_gnt  out  1  M0 beat accepted this cycle
- o_m0_rvalid  out  1  M0 read data valid
- o_m0_rdata  out  XLEN  M0 read data
- i_m1_req, i_m1_lock, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_size, o_m1_gnt, o_m1_rvalid, o_m1_rdata: same as M0
- o_s_addr  out  XLEN  RAM address
- o_s_wdata  out  XLEN  RAM write data
- o_s_size  out  2  RAM size
- o_s_we  out  1  RAM write strobe, qualified by grant
- i_s_rdata  in  XLEN  RAM read data, 1-cycle latency

Behaviour:
- Reset values: i_rst_n is the asynchronous, active-low reset and i_clk the clock. On reset: state=IDLE, owner=M0, last=M1, hold=0, rd_pend=0. All gnt, rvalid and o_s_we are 0. rdata and o_s_addr/wdata/size are 0.
- States: IDLE, OWN_M0, OWN_M1 (registered).
- IDLE, no requests: outputs quiescent.
- IDLE, one requester: that master is granted in the same cycle (combinational gnt) and the state moves to OWN_x.
- IDLE, both requesting: priority rule applies (see Optional Feature).
- OWN_x, x requesting: x is granted every cycle it asserts req.
  - If x deasserts req and lock is 0: next state is IDLE, or OWN_y if y is requesting (and y is granted that cycle).
  - If x deasserts req with lock=1: the state holds OWN_x with no grant issued.
- Lock precedence: lock is sampled only while x owns. Lock=1 overrides a pending y request, except for the hold limit.
- Hold counter:
  - Increments on each grant to the owner while the other master's req=1.
  - Resets to 0 on an owner change, or when the other master's req=0.
  - When hold==MAX_HOLD with the other master requesting: forced handover. The owner is not granted and the other master is granted that same cycle, lock notwithstanding.
- Slave mux:
  - o_s_addr/wdata/size follow the granted master, else the current owner's.
  - o_s_we = granted & we.
  - Exactly one gnt may be high per cycle.
- Read return:
  - Granted read (we=0) sets rd_pend=1 and rd_owner=granted master.
  - Next cycle: o_mX_rvalid=1 for rd_owner and o_mX_rdata=i_s_rdata.
  - rvalid is a 1-cycle pulse. A back-to-back read sets rd_pend again.
  - Reads issued just before a handover still return to the issuing master, even if ownership changed.
  - The non-owner's rdata holds its last value.
- Writes: completion is the gnt cycle; no rvalid is issued.
- Simultaneous events: a handover and a read return in the same cycle are independent and both occur.
- Invalid size=3: forwarded unchanged; RAM behaviour is undefined; the arbiter does not check it.
- Reset mid-operation: a pending read is dropped and no rvalid is issued after reset.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin. On a simultaneous request from IDLE, the master not equal to `last` wins. `last` updates to the granted master on every owner change.
- Undefined: fixed priority, M0 always wins from IDLE. `last` logic is removed.
- The hold limit applies in both modes.

Decomposition:
- Package arb_pkg:
  - arb_state_e {IDLE, OWN_M0, OWN_M1}
  - arb_master_e {M0, M1}
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants
  - default MAX_HOLD
- One sub-module, arb_hold_counter: saturating counter with clear/increment inputs and an at-limit flag.

Test Plan:
- Single M0 read: M0 req, addr 0x4000_0010, we=0, RAM returns 0xDEADBEEF. Expect m0_gnt in the same cycle, m0_rvalid=1 with rdata 0xDEADBEEF in the next cycle, and no M1 activity.
- Simultaneous request from IDLE (ARB_RR_EN off): M0 and M1 both req. Expect M0 granted.
- Simultaneous request from IDLE (ARB_RR_EN on, last=M0): expect M1 granted. Repeat with last=M1: expect M0 granted.
- Locked burst: M1 writes 4 words 0x4000_0000..0x4000_000C with lock=1 while M0 requests. Expect all 4 M1 grants first and o_s_we=1 on each. After M1 releases lock, expect M0 granted the following cycle.
- Starvation limit: MAX_HOLD=4, M0 continuous locked reads while M1 requests. Expect 4 M0 grants, then on the 5th cycle m1_gnt=1 and m0_gnt=0. The 4th M0 read's rvalid still arrives to M0.
- Reset mid-read: assert i_rst_n=0 the cycle after an M0 read grant. Expect no rvalid, all outputs 0, state IDLE. After release, a new M1 request is granted immediately.
